// File: rtl/brwb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : brwb_arbiter
//  Purpose  : Branch-writeback arbiter between BRU_NUM writeback channels and
//             the FTQ/ROB. Registers the channels, filters same-FTQ-entry
//             collisions (oldest wins), holds the oldest pending mispredict
//             redirect until ctrlBlock accepts it, and applies squash kills.
//  Optional : BRWB_PERF_CNT_EN adds saturating redirect-accept and
//             collision-filter counters.
//  Revision : 1.0 - initial release
// ============================================================================
module brwb_arbiter #(
   parameter int BRU_NUM = 2,
   parameter int ROB_W   = 7,
   parameter int FTQ_W   = 5,
   parameter int OFS_W   = 4,
   parameter int XLEN    = 64
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [BRU_NUM-1:0]                         i_wb_vld,
   input  logic [BRU_NUM*(ROB_W+1)-1:0]               i_wb_robIdx,
   input  logic [BRU_NUM*FTQ_W-1:0]                   i_wb_ftqIdx,
   input  logic [BRU_NUM*OFS_W-1:0]                   i_wb_ftqOfs,
   input  logic [BRU_NUM-1:0]                         i_wb_mispred,
   input  logic [BRU_NUM-1:0]                         i_wb_taken,
   input  logic [BRU_NUM*XLEN-1:0]                    i_wb_target,
   input  logic                                       i_squash_vld,
   input  logic [ROB_W:0]                             i_squash_robIdx,
   output logic [BRU_NUM-1:0]                         o_ftq_vld,
   output logic [BRU_NUM*(FTQ_W+OFS_W+2+XLEN)-1:0]    o_ftq_info,
   output logic                                       o_redirect_vld,
   output logic [ROB_W:0]                             o_redirect_robIdx,
   output logic [XLEN-1:0]                            o_redirect_target,
`ifdef BRWB_PERF_CNT_EN
   output logic [31:0]                                o_perf_mispred_cnt,
   output logic [31:0]                                o_perf_collide_cnt,
`endif
   input  logic                                       i_redirect_rdy
);

   localparam int RW     = ROB_W + 1;
   localparam int INFO_W = FTQ_W + OFS_W + 2 + XLEN;

   // A older than B: same wrap flag -> smaller index; different flag -> larger index
   function automatic logic older(input logic [ROB_W:0] a, input logic [ROB_W:0] b);
      if (a[ROB_W] == b[ROB_W]) return a[ROB_W-1:0] < b[ROB_W-1:0];
      else                      return a[ROB_W-1:0] > b[ROB_W-1:0];
   endfunction

   typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_HELD = 1'b1} state_t;

   logic [BRU_NUM-1:0]         s1_vld_q, s1_vld_d;
   logic [BRU_NUM*RW-1:0]      s1_rob_q, s1_rob_d;
   logic [BRU_NUM*FTQ_W-1:0]   s1_ftq_q, s1_ftq_d;
   logic [BRU_NUM*OFS_W-1:0]   s1_ofs_q, s1_ofs_d;
   logic [BRU_NUM-1:0]         s1_mis_q, s1_mis_d;
   logic [BRU_NUM-1:0]         s1_tkn_q, s1_tkn_d;
   logic [BRU_NUM*XLEN-1:0]    s1_tgt_q, s1_tgt_d;
   logic [BRU_NUM-1:0]         keep;
   logic                       c_vld;
   logic [ROB_W:0]             c_rob;
   logic [XLEN-1:0]            c_tgt;
   logic                       c_ok;
   logic                       r_kill;
   state_t                     state_q, state_d;
   logic [ROB_W:0]             r_rob_q, r_rob_d;
   logic [XLEN-1:0]            r_tgt_q, r_tgt_d;

   // S1 next values: capture every channel, dropping writebacks killed on entry
   always_comb begin
      s1_rob_d = i_wb_robIdx;
      s1_ftq_d = i_wb_ftqIdx;
      s1_ofs_d = i_wb_ftqOfs;
      s1_mis_d = i_wb_mispred;
      s1_tkn_d = i_wb_taken;
      s1_tgt_d = i_wb_target;
      s1_vld_d = '0;
      for (int i = 0; i < BRU_NUM; i++)
         s1_vld_d[i] = i_wb_vld[i] && !(i_squash_vld && older(i_squash_robIdx, i_wb_robIdx[i*RW +: RW]));
   end

   // S1 input register stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld_q <= '0;
         s1_rob_q <= '0;
         s1_ftq_q <= '0;
         s1_ofs_q <= '0;
         s1_mis_q <= '0;
         s1_tkn_q <= '0;
         s1_tgt_q <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_rob_q <= s1_rob_d;
         s1_ftq_q <= s1_ftq_d;
         s1_ofs_q <= s1_ofs_d;
         s1_mis_q <= s1_mis_d;
         s1_tkn_q <= s1_tkn_d;
         s1_tgt_q <= s1_tgt_d;
      end
   end

   // Same-FTQ-entry filter: a channel survives only if it beats every valid peer
   // on the same entry (older, or equal age and lower channel); kill-gated output
   always_comb begin
      keep       = '0;
      o_ftq_vld  = '0;
      o_ftq_info = '0;
      for (int j = 0; j < BRU_NUM; j++) begin
         keep[j] = s1_vld_q[j];
         for (int i = 0; i < BRU_NUM; i++) begin
            if (i != j && s1_vld_q[i] && s1_ftq_q[i*FTQ_W +: FTQ_W] == s1_ftq_q[j*FTQ_W +: FTQ_W]) begin
               if (!(older(s1_rob_q[j*RW +: RW], s1_rob_q[i*RW +: RW]) ||
                     (s1_rob_q[j*RW +: RW] == s1_rob_q[i*RW +: RW] && j < i)))
                  keep[j] = 1'b0;
            end
         end
         o_ftq_vld[j] = keep[j] && !(i_squash_vld && older(i_squash_robIdx, s1_rob_q[j*RW +: RW]));
         o_ftq_info[j*INFO_W +: INFO_W] = {s1_ftq_q[j*FTQ_W +: FTQ_W], s1_ofs_q[j*OFS_W +: OFS_W],
                                           s1_mis_q[j], s1_tkn_q[j], s1_tgt_q[j*XLEN +: XLEN]};
      end
   end

   // Redirect candidate: oldest valid mispredict in S1, lower channel on ties
   always_comb begin
      c_vld = 1'b0;
      c_rob = '0;
      c_tgt = '0;
      for (int i = 0; i < BRU_NUM; i++) begin
         if (s1_vld_q[i] && s1_mis_q[i] && (!c_vld || older(s1_rob_q[i*RW +: RW], c_rob))) begin
            c_vld = 1'b1;
            c_rob = s1_rob_q[i*RW +: RW];
            c_tgt = s1_tgt_q[i*XLEN +: XLEN];
         end
      end
   end

   // Redirect holder next-state: load, replace with older, release on accept/kill
   always_comb begin
      state_d = state_q;
      r_rob_d = r_rob_q;
      r_tgt_d = r_tgt_q;
      c_ok    = c_vld && !(i_squash_vld && older(i_squash_robIdx, c_rob));
      r_kill  = i_squash_vld && older(i_squash_robIdx, r_rob_q);
      case (state_q)
         ST_EMPTY: begin
            if (c_ok) begin
               state_d = ST_HELD;
               r_rob_d = c_rob;
               r_tgt_d = c_tgt;
            end
         end
         ST_HELD: begin
            if (c_ok && (r_kill || older(c_rob, r_rob_q))) begin
               r_rob_d = c_rob;
               r_tgt_d = c_tgt;
            end else if (r_kill || i_redirect_rdy) begin
               state_d = ST_EMPTY;
               r_rob_d = '0;
               r_tgt_d = '0;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            r_rob_d = '0;
            r_tgt_d = '0;
         end
      endcase
   end

   // Redirect holder register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
         r_rob_q <= '0;
         r_tgt_q <= '0;
      end else begin
         state_q <= state_d;
         r_rob_q <= r_rob_d;
         r_tgt_q <= r_tgt_d;
      end
   end

   assign o_redirect_vld    = (state_q == ST_HELD);
   assign o_redirect_robIdx = r_rob_q;
   assign o_redirect_target = r_tgt_q;

`ifdef BRWB_PERF_CNT_EN
   logic [31:0] mis_cnt_q, mis_cnt_d, col_cnt_q, col_cnt_d;
   logic [3:0]  n_filtered;
   logic [32:0] col_sum;

   // Saturating counters: redirect accepts and channels dropped by the filter
   always_comb begin
      n_filtered = '0;
      for (int i = 0; i < BRU_NUM; i++)
         n_filtered = n_filtered + {3'b000, s1_vld_q[i] && !keep[i]};
      col_sum   = {1'b0, col_cnt_q} + {29'd0, n_filtered};
      col_cnt_d = col_sum[32] ? '1 : col_sum[31:0];
      mis_cnt_d = mis_cnt_q;
      if (o_redirect_vld && i_redirect_rdy && mis_cnt_q != '1)
         mis_cnt_d = mis_cnt_q + 32'd1;
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_cnt_q <= '0;
         col_cnt_q <= '0;
      end else begin
         mis_cnt_q <= mis_cnt_d;
         col_cnt_q <= col_cnt_d;
      end
   end

   assign o_perf_mispred_cnt = mis_cnt_q;
   assign o_perf_collide_cnt = col_cnt_q;
`endif

endmodule
`default_nettype wire
